// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store memory port.
//   - ALU_* opcodes for the memory instructions and the ENABLE level used on
//     the is_load/is_store flags coming from the MEM stage.
//   - lsu_state_e : transaction state (IDLE, BUSY, RESP).
//   - lsu_size_e  : access width (byte, half, word).
//   - size_of / is_signed_load : decode an alucode into width and extension.
//   - be_gen / wdata_pos / misaligned : byte-lane helpers for one access.
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    localparam logic ENABLE = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    // Anything that is not a byte or half op is treated as a full word.
    function automatic lsu_size_e size_of(input logic [5:0] alucode);
        case (alucode)
            ALU_LB, ALU_LBU, ALU_SB: return SZ_B;
            ALU_LH, ALU_LHU, ALU_SH: return SZ_H;
            default:                 return SZ_W;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [5:0] alucode);
        return (alucode == ALU_LB) || (alucode == ALU_LH);
    endfunction

    function automatic logic [3:0] be_gen(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Bytes are replicated to every lane; halves are shifted into place.
    function automatic logic [31:0] wdata_pos(input lsu_size_e size, input logic [1:0] off,
                                              input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {16'h0000, wdata[15:0]} << {off, 3'b000};
            default: return wdata;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off == 2'd3;
            default: return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Combinational load extractor: picks the addressed byte/half out of a full
// memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_rdata  [31:0]  full word returned by memory
//   i_off    [1:0]   byte offset within the word
//   i_size           access width (lsu_size_e)
//   i_signed         1 = sign-extend byte/half
//   o_data   [31:0]  extended load result
// ----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  lsu_size_e   i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Bring the addressed lane down to bit 0 so byte and half share one path.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_B:    o_data = {{24{i_signed & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// ----------------------------------------------------------------------------
// lsu_mem_port
// Core-side load/store initiator. Takes one load or store from the MEM stage,
// issues a word-addressed memory request with byte enables, waits for the ack
// (or times out after WAIT_MAX cycles) and returns a one-cycle response.
// Ports:
//   i_clk, i_rst_n                 clock / async active-low reset
//   i_req_valid, o_req_ready       MEM stage handshake (ready only in IDLE)
//   i_alucode, i_is_load,
//   i_is_store, i_addr, i_wdata    the operation being offered
//   o_mem_req, o_mem_we,
//   o_mem_addr, o_mem_be,
//   o_mem_wdata                    memory request, held until i_mem_ack
//   i_mem_ack, i_mem_rdata         memory completion and read word
//   o_resp_valid, o_resp_data,
//   o_resp_misalign, o_resp_buserr one-cycle response and its fault flags
// ----------------------------------------------------------------------------
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [5:0]  i_alucode,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_data,
    output logic        o_resp_misalign,
    output logic        o_resp_buserr
);

    localparam int                CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_next_state;
    lsu_size_e        r_size;
    logic             r_signed;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [29:0]      r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_resp_data;
    logic             r_resp_misalign;
    logic             r_resp_buserr;

    lsu_size_e        w_size;
    logic             w_is_store;
    logic             w_op;
    logic             w_accept;
    logic             w_misalign;
    logic             w_ack;
    logic             w_timeout;
    logic [31:0]      w_load_data;

    lsu_load_align u_align (
        .i_rdata  (i_mem_rdata),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_load_data)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the per-state events. The ack only counts while the
    // request is actually out, so a late ack after a timeout is ignored.
    always_comb begin
        w_size       = size_of(i_alucode);
        w_is_store   = (i_is_store == ENABLE);
        w_op         = (i_is_load == ENABLE) || w_is_store;
        w_misalign   = misaligned(w_size, i_addr[1:0]);
        w_accept     = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                w_accept = i_req_valid & w_op;
                if (w_accept) begin
                    w_next_state = w_misalign ? RESP : BUSY;
                end
            end
            BUSY: begin
                w_ack     = i_mem_ack & r_mem_req;
                w_timeout = ~w_ack & (r_cnt == CNT_LAST);
                if (w_ack || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: the request is captured on accept, the wait counter runs in
    // BUSY, and the response fields are cleared again on the way out of RESP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_size          <= SZ_B;
            r_signed        <= 1'b0;
            r_off           <= 2'd0;
            r_cnt           <= '0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_be        <= 4'b0000;
            r_mem_wdata     <= '0;
            r_resp_data     <= '0;
            r_resp_misalign <= 1'b0;
            r_resp_buserr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_size          <= w_size;
                        r_signed        <= is_signed_load(i_alucode);
                        r_off           <= i_addr[1:0];
                        r_cnt           <= '0;
                        r_mem_req       <= ~w_misalign;
                        r_mem_we        <= w_is_store;
                        r_mem_addr      <= i_addr[31:2];
                        r_mem_be        <= be_gen(w_size, i_addr[1:0]);
                        r_mem_wdata     <= w_is_store ? wdata_pos(w_size, i_addr[1:0], i_wdata) : 32'h0;
                        r_resp_data     <= '0;
                        r_resp_misalign <= w_misalign;
                        r_resp_buserr   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (w_ack) begin
                        r_mem_req   <= 1'b0;
                        r_resp_data <= r_mem_we ? 32'h0 : w_load_data;
                    end else if (w_timeout) begin
                        r_mem_req     <= 1'b0;
                        r_resp_buserr <= 1'b1;
                        r_resp_data   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_resp_data     <= '0;
                    r_resp_misalign <= 1'b0;
                    r_resp_buserr   <= 1'b0;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready     = (r_state == IDLE);
    assign o_resp_valid    = (r_state == RESP);
    assign o_mem_req       = r_mem_req;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_be        = r_mem_be;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_resp_data     = r_resp_data;
    assign o_resp_misalign = r_resp_misalign;
    assign o_resp_buserr   = r_resp_buserr;

endmodule
